// File: rtl/pattern_vg_pkg.sv
// pattern_vg_pkg
//   Shared definitions for the pattern_vg controller slice: pattern codes,
//   divider FSM state type, default ramp_step width and the auto-cycle
//   successor function.
//   No ports (package).
package pattern_vg_pkg;

  localparam int unsigned PKG_B               = 8;
  localparam int unsigned PKG_FRACTIONAL_BITS = 12;
  localparam int unsigned RAMP_W              = PKG_B + PKG_FRACTIONAL_BITS;

  localparam logic [7:0] PAT_NONE   = 8'd0;
  localparam logic [7:0] PAT_BORDER = 8'd1;
  localparam logic [7:0] PAT_MOIREX = 8'd2;
  localparam logic [7:0] PAT_MOIREY = 8'd3;
  localparam logic [7:0] PAT_RAMP   = 8'd4;
  localparam logic [7:0] PAT_LAST   = PAT_RAMP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Auto-cycle successor: 1->2->3->4->1; anything outside 1..4 restarts at 1.
  function automatic logic [7:0] pat_next(input logic [7:0] p);
    if (p >= PAT_LAST || p < PAT_BORDER) return PAT_BORDER;
    return p + 8'd1;
  endfunction

endpackage

// File: rtl/pattern_vg_ramp_div.sv
// pattern_vg_ramp_div
//   Serial restoring divider computing 2^Q_W / divisor, one quotient bit per
//   cycle, Q_W+1 cycles per division. A quotient that does not fit in Q_W
//   bits (divisor 1) saturates to all-ones; divisor 0 yields 0 without
//   entering DIV.
// Ports
//   clk_in    in   1       clock
//   reset     in   1       asynchronous, active-high
//   start     in   1       start request, honoured only while idle
//   divisor   in   X_BITS  divisor, captured on start
//   busy      out  1       high for exactly the Q_W+1 DIV cycles
//   done      out  1       one-cycle pulse (DONE state), quotient valid
//   idle      out  1       FSM in IDLE
//   quotient  out  Q_W     last result, held until the next completion
module pattern_vg_ramp_div
  import pattern_vg_pkg::*;
#(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Q_W    = RAMP_W
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [X_BITS-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic              idle,
  output logic [Q_W-1:0]    quotient
);

  localparam int unsigned          CNT_W    = $clog2(Q_W + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(Q_W);

  div_state_t        state;
  logic [X_BITS-1:0] dvs;
  logic [X_BITS-1:0] rem;
  logic [Q_W-1:0]    quo;
  logic [CNT_W-1:0]  cnt;
  logic [X_BITS:0]   trial;
  logic              qbit;
  logic [X_BITS-1:0] rem_next;

  // The dividend is 1 followed by Q_W zeros, so the bit shifted into the
  // partial remainder is simply "first iteration"; no dividend register.
  always_comb begin
    trial    = {rem, (cnt == '0)};
    qbit     = (trial >= {1'b0, dvs});
    rem_next = qbit ? (trial[X_BITS-1:0] - dvs) : trial[X_BITS-1:0];
  end

  assign idle = (state == IDLE);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient <= '0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              dvs   <= divisor;
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= DIV;
            end
          end
        end
        DIV: begin
          rem <= rem_next;
          quo <= {quo[Q_W-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            // quo[Q_W-1] is bit Q_W of the full quotient: overflow.
            quotient <= quo[Q_W-1] ? '1 : {quo[Q_W-2:0], qbit};
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pattern_vg_ctrl.sv
// pattern_vg_ctrl
//   Frame-synchronous controller for pattern_vg. Selects the active pattern
//   (manual, or timed auto-cycle) and computes ramp_step =
//   2^(B+FRACTIONAL_BITS) / total_active_pix with a serial divider. Both
//   outputs change only on the frame-start (FS) cycle.
//   Build option: define PATTERN_VG_CTRL_AUTOCYCLE_EN to enable auto-cycle;
//   otherwise auto_en and frames_per_pattern are ignored (manual only).
// Ports
//   clk_in              in   1                   pixel clock
//   reset               in   1                   asynchronous, active-high
//   vn_in               in   1                   vsync; 1->0 marks frame start
//   total_active_pix    in   X_BITS              active pixels per line
//   auto_en             in   1                   auto-cycle enable
//   pattern_sel         in   8                   manual pattern code
//   frames_per_pattern  in   8                   auto dwell in frames (0 = 1)
//   pattern             out  8                   active pattern code
//   ramp_step           out  B+FRACTIONAL_BITS   fixed-point ramp increment
//   div_busy            out  1                   divider running
module pattern_vg_ctrl
  import pattern_vg_pkg::*;
#(
  parameter int unsigned B               = PKG_B,
  parameter int unsigned X_BITS          = 13,
  parameter int unsigned FRACTIONAL_BITS = PKG_FRACTIONAL_BITS,
  parameter int unsigned NUM_PATTERNS    = 5
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         vn_in,
  input  logic [X_BITS-1:0]            total_active_pix,
  input  logic                         auto_en,
  input  logic [7:0]                   pattern_sel,
  input  logic [7:0]                   frames_per_pattern,
  output logic [7:0]                   pattern,
  output logic [B+FRACTIONAL_BITS-1:0] ramp_step,
  output logic                         div_busy
);

  localparam int unsigned STEP_W       = B + FRACTIONAL_BITS;
  localparam logic [7:0]  NUM_PAT_CODE = 8'(NUM_PATTERNS);

  logic              vn_q;
  logic              fs;
  logic [X_BITS-1:0] pix_q;
  logic              div_start;
  logic              div_done;
  logic              div_idle;
  logic [STEP_W-1:0] div_q;
  logic [STEP_W-1:0] step_pend;
  logic              pend_valid;
  logic [7:0]        sel_code;

  // A change arriving while the divider is active is simply seen again
  // at the next FS, since pix_q still holds the old value.
  assign div_start = fs && div_idle && (total_active_pix != pix_q);
  assign sel_code  = (pattern_sel < NUM_PAT_CODE) ? pattern_sel : PAT_NONE;

  pattern_vg_ramp_div #(
    .X_BITS (X_BITS),
    .Q_W    (STEP_W)
  ) u_div (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (div_start),
    .divisor  (total_active_pix),
    .busy     (div_busy),
    .done     (div_done),
    .idle     (div_idle),
    .quotient (div_q)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      vn_q       <= 1'b0;
      fs         <= 1'b0;
      pix_q      <= '0;
      step_pend  <= '0;
      pend_valid <= 1'b0;
      ramp_step  <= '0;
    end else begin
      vn_q <= vn_in;
      fs   <= vn_q & ~vn_in;
      if (div_start) pix_q <= total_active_pix;
      if (div_done) begin
        step_pend  <= div_q;
        pend_valid <= 1'b1;
      end else if (fs && pend_valid) begin
        ramp_step  <= step_pend;
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef PATTERN_VG_CTRL_AUTOCYCLE_EN
  logic [7:0] frame_cnt;
  logic [7:0] dwell_last;
  logic       auto_q;

  assign dwell_last = (frames_per_pattern == '0) ? '0 : (frames_per_pattern - 8'd1);

  // auto_q remembers the mode applied at the previous FS so a mode switch
  // is recognised (and the counter restarted) on the FS that applies it.
  // >= rather than == keeps a mid-dwell reduction of frames_per_pattern
  // from running the counter all the way round.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pattern   <= PAT_NONE;
      frame_cnt <= '0;
      auto_q    <= 1'b0;
    end else if (fs) begin
      auto_q <= auto_en;
      if (!auto_en) begin
        pattern   <= sel_code;
        frame_cnt <= '0;
      end else if (!auto_q) begin
        pattern   <= PAT_BORDER;
        frame_cnt <= '0;
      end else if (frame_cnt >= dwell_last) begin
        pattern   <= pat_next(pattern);
        frame_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_auto;
  assign unused_auto = &{1'b0, auto_en, frames_per_pattern};

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pattern <= PAT_NONE;
    end else if (fs) begin
      pattern <= sel_code;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_vg_ctrl.sv
module tb_pattern_vg_ctrl;

  logic        clk_in;
  logic        reset;
  logic        vn_in;
  logic [12:0] total_active_pix;
  logic        auto_en;
  logic [7:0]  pattern_sel;
  logic [7:0]  frames_per_pattern;
  logic [7:0]  pattern;
  logic [19:0] ramp_step;
  logic        div_busy;

  typedef struct {
    string       tag;
    logic [7:0]  pat;
    logic [19:0] step;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  cur_pat;
  logic [19:0] cur_step;

  pattern_vg_ctrl #(
    .B               (8),
    .X_BITS          (13),
    .FRACTIONAL_BITS (12),
    .NUM_PATTERNS    (5)
  ) dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .vn_in              (vn_in),
    .total_active_pix   (total_active_pix),
    .auto_en            (auto_en),
    .pattern_sel        (pattern_sel),
    .frames_per_pattern (frames_per_pattern),
    .pattern            (pattern),
    .ramp_step          (ramp_step),
    .div_busy           (div_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [19:0] model_step(input int unsigned pix);
    longint unsigned q;
    if (pix == 0) return '0;
    q = (64'd1 << 20) / 64'(pix);
    if (q > 64'hFFFFF) return 20'hFFFFF;
    return q[19:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] p, input logic [19:0] s);
    exp_t e;
    e.tag  = tag;
    e.pat  = p;
    e.step = s;
    sb.push_back(e);
  endtask

  // Raise vsync, drop it, and compare outputs one cycle before and exactly
  // one cycle after the FS cycle against the next scoreboard entry.
  task automatic do_fs();
    exp_t e;
    @(posedge clk_in); #1 vn_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 vn_in = 1'b0;
    @(posedge clk_in); #1;
    check("pre_fs_pattern", 32'(pattern), 32'(cur_pat));
    check("pre_fs_ramp", 32'(ramp_step), 32'(cur_step));
    @(posedge clk_in); #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_pattern"}, 32'(pattern), 32'(e.pat));
      check({e.tag, "_ramp"}, 32'(ramp_step), 32'(e.step));
      cur_pat  = e.pat;
      cur_step = e.step;
    end
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n;
    n = 0;
    while (div_busy === 1'b1 && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int hi;
    reset              = 1'b1;
    vn_in              = 1'b0;
    total_active_pix   = '0;
    auto_en            = 1'b0;
    pattern_sel        = '0;
    frames_per_pattern = '0;
    cur_pat            = '0;
    cur_step           = '0;

    #12;
    check("reset_pattern", 32'(pattern), 32'd0);
    check("reset_ramp", 32'(ramp_step), 32'd0);
    check("reset_busy", 32'(div_busy), 32'd0);
    @(negedge clk_in) reset = 1'b0;

    // 1280 -> 819 after one full division and the following FS.
    total_active_pix = 13'd1280;
    push_exp("fs1", 8'd0, 20'd0);
    do_fs();
    check("div_starts_on_fs", 32'(div_busy), 32'd1);
    busy_len("div1280_len", 21);

    pattern_sel = 8'd3;
    repeat (5) @(posedge clk_in);
    #1 check("sel_midframe_hold", 32'(pattern), 32'd0);
    push_exp("fs2", 8'd3, 20'h333);
    do_fs();

    // 1280 -> 1920: old step holds for one more frame.
    pattern_sel      = 8'd9;
    total_active_pix = 13'd1920;
    push_exp("fs3", 8'd0, 20'd819);
    do_fs();
    busy_len("div1920_len", 21);
    push_exp("fs4", 8'd0, 20'd546);
    do_fs();
    pattern_sel = 8'd1;
    push_exp("fs5", 8'd1, 20'd546);
    do_fs();

    // Divisor 0: no DIV phase, result 0.
    total_active_pix = 13'd0;
    pattern_sel      = 8'd4;
    push_exp("fs6", 8'd4, 20'd546);
    do_fs();
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      if (div_busy !== 1'b0) hi++;
      @(posedge clk_in); #1;
    end
    check("div0_no_busy", 32'(hi), 32'd0);
    push_exp("fs7", 8'd4, 20'd0);
    do_fs();

    // Divisor 1: saturates.
    total_active_pix = 13'd1;
    push_exp("fs8", 8'd4, 20'd0);
    do_fs();
    busy_len("div1_len", 21);
    push_exp("fs9", 8'd4, 20'hFFFFF);
    do_fs();

    total_active_pix = 13'd1000;
    push_exp("fs10", 8'd4, 20'hFFFFF);
    do_fs();
    busy_len("div1000_len", 21);
    push_exp("fs11", 8'd4, model_step(1000));
    do_fs();

    auto_en            = 1'b1;
    frames_per_pattern = 8'd2;
    pattern_sel        = 8'd2;
`ifdef PATTERN_VG_CTRL_AUTOCYCLE_EN
    begin
      logic [7:0] seq [9];
      seq = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd1};
      for (int i = 0; i < 9; i++) begin
        push_exp($sformatf("auto2_%0d", i), seq[i], cur_step);
        do_fs();
      end
      frames_per_pattern = 8'd0;
      for (int i = 0; i < 4; i++) begin
        push_exp($sformatf("auto0_%0d", i), (i == 3) ? 8'd1 : 8'(i + 2), cur_step);
        do_fs();
      end
    end
`else
    push_exp("auto_ignored_a", 8'd2, cur_step);
    do_fs();
    push_exp("auto_ignored_b", 8'd2, cur_step);
    do_fs();
`endif
    auto_en     = 1'b0;
    pattern_sel = 8'd1;
    push_exp("manual_back", 8'd1, cur_step);
    do_fs();

    // Asynchronous reset in the middle of a division.
    total_active_pix = 13'd1280;
    push_exp("pre_reset", 8'd1, cur_step);
    do_fs();
    repeat (5) @(posedge clk_in);
    #1 check("mid_div_busy", 32'(div_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pattern", 32'(pattern), 32'd0);
    check("async_rst_ramp", 32'(ramp_step), 32'd0);
    check("async_rst_busy", 32'(div_busy), 32'd0);
    @(negedge clk_in) reset = 1'b0;
    cur_pat  = '0;
    cur_step = '0;

    push_exp("post_rst1", 8'd1, 20'd0);
    do_fs();
    busy_len("post_rst_div_len", 21);
    push_exp("post_rst2", 8'd1, 20'd819);
    do_fs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
